seg7_scan_mux: RTL and testbench

- Parametrised, time-multiplexed seven-segment display driver for the board's common-anode displays.
- Scans NUM_DIGITS digits through a free-running prescaler and a digit counter.
- Per digit: decodes a 4-bit hex nibble to active-low segments; drives one active-low anode and the decimal point.
- Frame-synchronous double buffering: host updates never tear mid-frame.
- Sits between user/audio status logic and the top-level an/seg/dp pins.

---
 rtl/seg7_scan_mux.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous double buffering.
// Optional per-slot anode duty control is built when SEG7_SCAN_BRIGHTNESS_EN is defined.
module seg7_scan_mux #(
   parameter  int NUM_DIGITS = 8,
   parameter  int DIV_WIDTH  = 17,
   localparam int SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      en,
   input  logic                      update,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     blank,
   input  logic [NUM_DIGITS-1:0]     dp_mask,
`ifdef SEG7_SCAN_BRIGHTNESS_EN
   input  logic [3:0]                brightness,
`endif
   output logic [NUM_DIGITS-1:0]     an,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [SEL_W-1:0]          digit_sel,
   output logic                      pending,
   output logic                      frame_done
);

   localparam logic [SEL_W-1:0]      LAST_SEL = SEL_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ALL_ONE  = {NUM_DIGITS{1'b1}};

   logic [DIV_WIDTH-1:0]    r_cnt;
   logic [SEL_W-1:0]        r_sel;
   logic                    r_pending;
   logic                    r_frame_done;
   logic [4*NUM_DIGITS-1:0] r_stg_digits;
   logic [NUM_DIGITS-1:0]   r_stg_blank;
   logic [NUM_DIGITS-1:0]   r_stg_dp;
   logic [4*NUM_DIGITS-1:0] r_act_digits;
   logic [NUM_DIGITS-1:0]   r_act_blank;
   logic [NUM_DIGITS-1:0]   r_act_dp;
   logic [NUM_DIGITS-1:0]   r_an;
   logic [6:0]              r_seg;
   logic                    r_dp;

   logic                    w_tick;
   logic                    w_boundary;
   logic [3:0]              w_nibble;
   logic                    w_dark;
   logic [NUM_DIGITS-1:0]   w_an_next;
   logic [6:0]              w_seg_next;
   logic                    w_dp_next;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign w_tick     = en & (&r_cnt);
   assign w_boundary = w_tick & (r_sel == LAST_SEL);

   // Prescaler wraps naturally at 2**DIV_WIDTH-1; everything freezes while en is low.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sel        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_boundary;
         if (w_tick) begin
            r_sel <= (r_sel == LAST_SEL) ? '0 : r_sel + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stg_digits <= '0;
         r_stg_blank  <= ALL_ONE;
         r_stg_dp     <= '0;
      end else if (update) begin
         r_stg_digits <= digits;
         r_stg_blank  <= blank;
         r_stg_dp     <= dp_mask;
      end
   end

   // A host write landing on the boundary cycle bypasses staging so it is shown in the new frame.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_act_digits <= '0;
         r_act_blank  <= ALL_ONE;
         r_act_dp     <= '0;
         r_pending    <= 1'b0;
      end else if (w_boundary) begin
         r_pending <= 1'b0;
         if (update) begin
            r_act_digits <= digits;
            r_act_blank  <= blank;
            r_act_dp     <= dp_mask;
         end else if (r_pending) begin
            r_act_digits <= r_stg_digits;
            r_act_blank  <= r_stg_blank;
            r_act_dp     <= r_stg_dp;
         end
      end else if (update) begin
         r_pending <= 1'b1;
      end
   end

   always_comb begin
      w_nibble   = r_act_digits[{r_sel, 2'b00} +: 4];
      w_dark     = ~en | r_act_blank[r_sel];
      w_an_next  = w_dark ? ALL_ONE : ~(NUM_DIGITS'(1) << r_sel);
`ifdef SEG7_SCAN_BRIGHTNESS_EN
      // Duty control compares the top prescaler nibble, so only the anode is gated.
      if (!w_dark && (r_cnt[DIV_WIDTH-1 -: 4] > brightness)) begin
         w_an_next = ALL_ONE;
      end
`endif
      w_seg_next = w_dark ? 7'h7F : hex7(w_nibble);
      w_dp_next  = w_dark | ~r_act_dp[r_sel];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_an  <= ALL_ONE;
         r_seg <= 7'h7F;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an_next;
         r_seg <= w_seg_next;
         r_dp  <= w_dp_next;
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign digit_sel  = r_sel;
   assign pending    = r_pending;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized bench for seg7_scan_mux; reference model tracks scan position as an enabled-cycle count.
module tb_seg7_scan_mux;

   localparam int ND    = 8;
   localparam int DW    = 4;
   localparam int SW    = 3;
   localparam int SLOT  = 1 << DW;
   localparam int FRAME = SLOT * ND;

   logic          clk = 1'b0;
   logic          rstn;
   logic          en;
   logic          update;
   logic [31:0]   digits;
   logic [7:0]    blank;
   logic [7:0]    dp_mask;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
   logic [3:0]    brightness;
`endif
   logic [7:0]    an;
   logic [6:0]    seg;
   logic          dp;
   logic [SW-1:0] digit_sel;
   logic          pending;
   logic          frame_done;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: n counts enabled cycles since reset.
   int          n;
   logic [31:0] m_act_d, m_stg_d;
   logic [7:0]  m_act_b, m_stg_b, m_act_p, m_stg_p;
   bit          m_pend;
   logic [6:0]  hex_lut [16];

   seg7_scan_mux #(.NUM_DIGITS(ND), .DIV_WIDTH(DW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en),
      .update     (update),
      .digits     (digits),
      .blank      (blank),
      .dp_mask    (dp_mask),
`ifdef SEG7_SCAN_BRIGHTNESS_EN
      .brightness (brightness),
`endif
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .digit_sel  (digit_sel),
      .pending    (pending),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic step(input logic e, input logic u, input logic [31:0] d,
                       input logic [7:0] b, input logic [7:0] p);
      int         sel;
      bit         dark;
      bit         bnd;
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      logic [3:0] nib;
      en = e; update = u; digits = d; blank = b; dp_mask = p;
      sel     = (n / SLOT) % ND;
      dark    = !e || m_act_b[sel];
      exp_an  = dark ? 8'hFF : ~(8'h01 << sel);
`ifdef SEG7_SCAN_BRIGHTNESS_EN
      if (!dark && ((n % SLOT) / (SLOT / 16 > 0 ? SLOT / 16 : 1)) > int'(brightness)) exp_an = 8'hFF;
`endif
      nib     = 4'((m_act_d >> (4 * sel)) & 32'hF);
      exp_seg = dark ? 7'h7F : hex_lut[nib];
      exp_dp  = dark ? 1'b1 : ~m_act_p[sel];
      bnd     = e && ((n % FRAME) == FRAME - 1);
      if (u) begin
         m_stg_d = d; m_stg_b = b; m_stg_p = p;
      end
      if (bnd) begin
         if (m_pend || u) begin
            m_act_d = m_stg_d; m_act_b = m_stg_b; m_act_p = m_stg_p;
         end
         m_pend = 0;
      end else if (u) begin
         m_pend = 1;
      end
      if (e) n++;
      @(posedge clk);
      #1;
      check_eq("an", an, exp_an);
      check_eq("seg", seg, exp_seg);
      check_eq("dp", dp, exp_dp);
      check_eq("digit_sel", digit_sel, (n / SLOT) % ND);
      check_eq("pending", pending, m_pend);
      check_eq("frame_done", frame_done, bnd);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, $urandom, 8'($urandom), 8'($urandom));
   endtask

   task automatic run_to(input int phase);
      int guard;
      guard = 0;
      while (((n % FRAME) != phase) && (guard < 2 * FRAME)) begin
         step(1'b1, 1'b0, $urandom, 8'($urandom), 8'($urandom));
         guard++;
      end
      check_eq("run_to_bound", guard < 2 * FRAME, 1);
   endtask

   initial begin
      hex_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      n = 0; m_pend = 0;
      m_act_d = '0; m_stg_d = '0; m_act_b = 8'hFF; m_stg_b = 8'hFF; m_act_p = '0; m_stg_p = '0;
      rstn = 1'b0; en = 1'b0; update = 1'b0; digits = '0; blank = '0; dp_mask = '0;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
      brightness = 4'hF;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_an", an, 8'hFF);
      check_eq("rst_seg", seg, 7'h7F);
      check_eq("rst_dp", dp, 1'b1);
      check_eq("rst_sel", digit_sel, 0);
      check_eq("rst_pending", pending, 0);
      check_eq("rst_frame_done", frame_done, 0);
      rstn = 1'b1;

      // Idle: display stays dark, scan runs.
      idle(FRAME + 20);

      // Scan/decode pattern.
      step(1'b1, 1'b1, 32'h76543210, 8'h00, 8'h40);
      idle(2 * FRAME);

      // Anti-tear: mid-frame write held until the boundary.
      run_to(50);
      step(1'b1, 1'b1, 32'hFFFFFFFF, 8'h00, 8'h00);
      idle(FRAME + 10);

      // Overwrite: only the second write is shown.
      run_to(20);
      step(1'b1, 1'b1, $urandom, 8'h00, 8'($urandom));
      run_to(60);
      step(1'b1, 1'b1, 32'h0123ABCD, 8'h00, 8'h81);
      idle(FRAME);

      // Update exactly on the boundary cycle.
      run_to(FRAME - 1);
      step(1'b1, 1'b1, 32'hC0FFEE42, 8'h00, 8'h3C);
      idle(20);

      // Enable low mid-digit, then resume.
      run_to(37);
      for (int i = 0; i < 9; i++) step(1'b0, (i == 4), $urandom, 8'h00, 8'($urandom));
      idle(FRAME + 10);

      // Blanked digit 1.
      step(1'b1, 1'b1, $urandom, 8'h02, 8'hFF);
      idle(2 * FRAME);

`ifdef SEG7_SCAN_BRIGHTNESS_EN
      brightness = 4'd3;
      idle(FRAME);
      brightness = 4'd15;
      idle(FRAME);
`endif

      // Randomized traffic.
      for (int i = 0; i < 2500; i++) begin
`ifdef SEG7_SCAN_BRIGHTNESS_EN
         if ((i % 64) == 0) brightness = 4'($urandom_range(0, 15));
`endif
         step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom,
              8'($urandom_range(0, 3) == 0 ? $urandom : 0), 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
